// File: rtl/load_store_unit.sv
// Load/store unit: one core access at a time onto a req/gnt/rvalid memory port, with sizing,
// lane shifting and load extension. Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_we,
    input  logic [1:0]                          req_size,
    input  logic                                req_unsigned,
    input  logic [ADDR_W-1:0]                   req_addr,
    input  logic [XLEN-1:0]                     req_wdata,
    output logic                                resp_valid,
    output logic                                resp_err,
    output logic [XLEN-1:0]                     resp_rdata,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [XLEN/8-1:0]                   mem_be,
    output logic [ADDR_W-$clog2(XLEN/8)-1:0]    mem_addr,
    output logic [XLEN-1:0]                     mem_wdata,
    input  logic                                mem_gnt,
    input  logic                                mem_rvalid,
    input  logic [XLEN-1:0]                     mem_rdata
);
    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned AW  = ADDR_W - OFF;
    localparam int unsigned IW  = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e          state_q;
    logic            we_q;
    logic            uns_q;
    logic [1:0]      size_q;
    logic [OFF-1:0]  off_q;
    logic            err_q;
    logic [XLEN-1:0] rdata_q;

    logic            req_ready_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [NB-1:0]   mem_be_q;
    logic [AW-1:0]   mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    logic [OFF-1:0]  off_c;
    logic            bad_c;
    logic [NB-1:0]   be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] shift_c;
    logic [XLEN-1:0] load_c;
    logic [6:0]      nbits_c;
    logic            sign_c;

    // Request decode: alignment, byte enables and lane-shifted store data.
    always_comb begin
        off_c = req_addr[OFF-1:0];
        case (req_size)
            2'd0:    bad_c = 1'b0;
            2'd1:    bad_c = off_c[0];
            2'd2:    bad_c = (off_c[1:0] != 2'b00);
            default: bad_c = (XLEN == 32) || (off_c != '0);
        endcase
        be_c = '0;
        for (int i = 0; i < int'(NB); i++) begin
            be_c[i] = (i >= int'(off_c)) && (i < int'(off_c) + (1 << req_size));
        end
        wdata_c = req_wdata << {off_c, 3'b000};
    end

    // Load path: shift the addressed lane down, then sign/zero extend from the access width.
    always_comb begin
        nbits_c = 7'(8 << size_q);
        shift_c = mem_rdata >> {off_q, 3'b000};
        sign_c  = ~uns_q & shift_c[IW'(nbits_c - 7'd1)];
        load_c  = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            load_c[i] = (i < int'(nbits_c)) ? shift_c[i] : sign_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'd0;
            off_q        <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        uns_q       <= req_unsigned;
                        size_q      <= req_size;
                        off_q       <= off_c;
                        err_q       <= bad_c;
                        if (bad_c) begin
                            state_q <= S_RESP;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_be_q    <= be_c;
                            mem_addr_q  <= req_addr[ADDR_W-1:OFF];
                            mem_wdata_q <= wdata_c;
                            state_q     <= S_REQ;
`ifdef LSU_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        rdata_q     <= '0;
                        state_q     <= we_q ? S_RESP : S_WAIT;
`ifdef LSU_TIMEOUT_EN
                        cnt_q       <= '0;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        err_q       <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q       <= cnt_q + CW'(1);
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= load_c;
                        state_q <= S_RESP;
`ifdef LSU_TIMEOUT_EN
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
`endif
                    end
                end
                S_RESP: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    resp_rdata_q <= err_q ? '0 : rdata_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array memory model; covers the
// LSU_TIMEOUT_EN watchdog when that macro is defined.
module tb_load_store_unit;
`ifdef LSU_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem_words [0:16383];
    logic [7:0]  ref_mem   [0:65535];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .ADDR_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One access: drive the request, act as the memory, check against the byte-level model.
    task automatic do_access(input bit we, input bit [1:0] sz, input bit uns,
                             input logic [15:0] addr, input logic [31:0] wd,
                             input int gd, input int rvd, input bit nogrant,
                             output logic [31:0] rd_o);
        int          n, off, k, gk, reqc, pulses, instab, badreq, rdyhigh, exp_lat;
        bit          mis, exp_err, granted, done;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;
        logic [13:0] exp_ad;
        logic [63:0] v;
        n       = 1 << sz;
        off     = int'(addr[1:0]);
        mis     = (sz == 2'd3) || ((off % n) != 0);
        exp_err = mis || nogrant;
        exp_be  = 4'(((1 << n) - 1) << off);
        exp_wd  = 32'(64'(wd) << (8 * off));
        exp_ad  = addr[15:2];
        exp_rd  = '0;
        if (!exp_err && !we) begin
            v = '0;
            for (int b = 0; b < n; b++) v |= 64'(ref_mem[int'(addr) + b]) << (8 * b);
            if (!uns && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
            exp_rd = v[31:0];
        end
        if (mis)          exp_lat = 1;
        else if (nogrant) exp_lat = TO + 1;
        else if (we)      exp_lat = 2 + gd;
        else              exp_lat = 3 + gd + rvd;
        rd_o = '0;

        k = 0;
        while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
        check("rdy_before", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = $urandom; req_addr = 16'($urandom);

        k = 0; gk = 0; reqc = 0; pulses = 0; instab = 0; badreq = 0; rdyhigh = 0;
        granted = 0; done = 0;
        while (!done && k < 400) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (mem_req) begin
                if (mis) badreq++;
                if ({mem_we, mem_be, mem_addr, mem_wdata} !== {we, exp_be, exp_ad, exp_wd}) instab++;
                if (!granted) begin
                    reqc++;
                    if (!nogrant && reqc == gd + 1) begin
                        mem_gnt = 1'b1; granted = 1; gk = k;
                        check("gnt_we", 64'(mem_we), 64'(we));
                        check("gnt_be", 64'(mem_be), 64'(exp_be));
                        check("gnt_addr", 64'(mem_addr), 64'(exp_ad));
                        check("gnt_wdata", 64'(mem_wdata), 64'(exp_wd));
                        if (we)
                            for (int b = 0; b < 4; b++)
                                if (mem_be[b]) mem_words[int'(mem_addr)][8*b +: 8] = mem_wdata[8*b +: 8];
                    end else begin
                        mem_rvalid = 1'b1;
                    end
                end
            end
            if (granted && !we && k > gk) begin
                if (k == gk + 1 + rvd) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_words[int'(exp_ad)];
                end else if (k < gk + 1 + rvd) begin
                    mem_gnt = 1'(k % 2);
                end
            end
            if (resp_valid) begin
                pulses++;
                if (pulses == 1) begin
                    check("lat", 64'(k), 64'(exp_lat));
                    check("err", 64'(resp_err), 64'(exp_err));
                    check("rdata", 64'(resp_rdata), 64'(exp_rd));
                    rd_o = resp_rdata;
                end
            end else if (pulses > 0) begin
                check("rdy_after", 64'(req_ready), 64'd1);
                done = 1;
            end
            if (!done && req_ready) rdyhigh++;
            if (!done) begin @(posedge clk); #1; k++; end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check("pulses", 64'(pulses), 64'd1);
        check("rdy_low", 64'(rdyhigh), 64'd0);
        check("mem_stable", 64'(instab), 64'd0);
        check("no_mreq_err", 64'(badreq), 64'd0);
        if (we && !exp_err)
            for (int b = 0; b < n; b++) ref_mem[int'(addr) + b] = wd[8*b +: 8];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] rd;
        int          pulses, mreqs;
        for (int w = 0; w < 16384; w++) begin
            mem_words[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = mem_words[w][8*b +: 8];
        end
        mem_words[1] = 32'h8001_1234;
        ref_mem[4] = 8'h34; ref_mem[5] = 8'h12; ref_mem[6] = 8'h01; ref_mem[7] = 8'h80;

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy0", 64'(req_ready), 64'd0);
        check("rst_mreq0", 64'(mem_req), 64'd0);
        check("rst_resp0", 64'(resp_valid), 64'd0);
        check("rst_be0", 64'(mem_be), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_rdy1", 64'(req_ready), 64'd1);

        do_access(1'b1, 2'd0, 1'b0, 16'h0003, 32'h0000_00AB, 0, 0, 1'b0, rd);
        do_access(1'b0, 2'd1, 1'b0, 16'h0006, 32'h0, 0, 0, 1'b0, rd);
        check("half_signed", 64'(rd), 64'hFFFF_8001);
        do_access(1'b0, 2'd1, 1'b1, 16'h0006, 32'h0, 0, 0, 1'b0, rd);
        check("half_unsigned", 64'(rd), 64'h0000_8001);
        do_access(1'b0, 2'd2, 1'b0, 16'h0002, 32'h0, 0, 0, 1'b0, rd);
        do_access(1'b0, 2'd3, 1'b0, 16'h0000, 32'h0, 0, 0, 1'b0, rd);
        do_access(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 5, 3, 1'b0, rd);
        do_access(1'b1, 2'd2, 1'b0, 16'h0010, 32'hCAFE_F00D, 5, 0, 1'b0, rd);
        do_access(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0, 0, 0, 1'b0, rd);
        check("byte_signed", 64'(rd), 64'hFFFF_FFCA);

        // Reset in the middle of a load that is never granted.
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 16'h0008; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid_mreq", 64'(mem_req), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0; pulses = 0; mreqs = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) check("rst_mreq_drop", 64'(mem_req), 64'd0);
            pulses += int'(resp_valid);
        end
        check("rst_rdy_held", 64'(req_ready), 64'd0);
        rst = 1'b1; mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) check("rst_rdy_rel", 64'(req_ready), 64'd1);
            pulses += int'(resp_valid);
            mreqs  += int'(mem_req);
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        check("rst_no_pulse", 64'(pulses), 64'd0);
        check("rst_no_mreq", 64'(mreqs), 64'd0);

`ifdef LSU_TIMEOUT_EN
        do_access(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 0, 0, 1'b1, rd);
        do_access(1'b1, 2'd2, 1'b0, 16'h0020, 32'h1234_5678, 0, 0, 1'b1, rd);
        do_access(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 1, 1, 1'b0, rd);
`endif

        for (int t = 0; t < 150; t++) begin
            do_access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                      16'($urandom_range(0, 63)), $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
